// File: rtl/lfsr_checker_pkg.sv
// rtl/lfsr_checker_pkg.sv - shared LFSR tap table and checker state encoding
package lfsr_checker_pkg;

    typedef enum logic [1:0] {
        ST_FILL   = 2'd0,
        ST_CHECK  = 2'd1,
        ST_LOCKED = 2'd2
    } chk_state_t;

    // XNOR tap masks for maximal-length sequences; tap k sits at bit k-1.
    // The generator uses the same table so the two ends cannot diverge.
    function automatic logic [31:0] lfsr_tap_mask(input int n);
        case (n)
            3:       return 32'h0000_0006;
            4:       return 32'h0000_000C;
            5:       return 32'h0000_0014;
            6:       return 32'h0000_0030;
            7:       return 32'h0000_0060;
            8:       return 32'h0000_00B8;
            9:       return 32'h0000_0110;
            10:      return 32'h0000_0240;
            11:      return 32'h0000_0500;
            12:      return 32'h0000_0829;
            13:      return 32'h0000_100D;
            14:      return 32'h0000_2015;
            15:      return 32'h0000_6000;
            16:      return 32'h0000_D008;
            17:      return 32'h0001_2000;
            18:      return 32'h0002_0400;
            19:      return 32'h0004_0023;
            20:      return 32'h0009_0000;
            21:      return 32'h0014_0000;
            22:      return 32'h0030_0000;
            23:      return 32'h0042_0000;
            24:      return 32'h00E1_0000;
            25:      return 32'h0120_0000;
            26:      return 32'h0200_0023;
            27:      return 32'h0400_0013;
            28:      return 32'h0900_0000;
            29:      return 32'h1400_0000;
            30:      return 32'h2000_0029;
            31:      return 32'h4800_0000;
            32:      return 32'h8020_0003;
            default: return 32'h0000_0000;
        endcase
    endfunction

endpackage

// File: rtl/lfsr_feedback.sv
// rtl/lfsr_feedback.sv - XNOR feedback bit f(R) of an NUM_BITS-long LFSR
//   lfsr_data  in  NUM_BITS  register contents (LSB newest)
//   feedback   out 1         XNOR chain of the tapped bits
module lfsr_feedback
    import lfsr_checker_pkg::*;
#(
    parameter int NUM_BITS = 32
) (
    input  logic [NUM_BITS-1:0] lfsr_data,
    output logic                feedback
);

    localparam logic [31:0]          TAP_MASK_FULL = lfsr_tap_mask(NUM_BITS);
    localparam logic [NUM_BITS-1:0]  TAP_MASK      = TAP_MASK_FULL[NUM_BITS-1:0];
    // A chain of XNORs over k operands is their XOR, inverted when k is even.
    localparam logic                 TAP_EVEN      = ~(^TAP_MASK);

    assign feedback = (^(lfsr_data & TAP_MASK)) ^ TAP_EVEN;

endmodule

// File: rtl/lfsr_checker.sv
// rtl/lfsr_checker.sv - self-synchronising PRBS checker with flywheel and error count
//   i_Clk        in  1          clock
//   i_Rst        in  1          synchronous active-high reset
//   i_Bit_DV     in  1          i_Bit valid; everything holds when low
//   i_Bit        in  1          received PRBS bit
//   i_Clr_Cnt    in  1          clear o_Err_Count (wins over increment)
//   o_Locked     out 1          checker is locked
//   o_Bit_Err    out 1          previous valid bit mismatched while locked
//   o_Err_Count  out ERR_CNT_W  saturating mismatch count while locked
//   o_LFSR_Data  out NUM_BITS   checker shift register
module lfsr_checker
    import lfsr_checker_pkg::*;
#(
    parameter int NUM_BITS  = 32,
    parameter int LOCK_CNT  = 64,
    parameter int WINDOW    = 256,
    parameter int ERR_LIMIT = 8,
    parameter int ERR_CNT_W = 16
) (
    input  logic                 i_Clk,
    input  logic                 i_Rst,
    input  logic                 i_Bit_DV,
    input  logic                 i_Bit,
    input  logic                 i_Clr_Cnt,
    output logic                 o_Locked,
    output logic                 o_Bit_Err,
    output logic [ERR_CNT_W-1:0] o_Err_Count,
    output logic [NUM_BITS-1:0]  o_LFSR_Data
);

    localparam int FILL_W  = $clog2(NUM_BITS);
    localparam int MATCH_W = $clog2(LOCK_CNT + 1);
    localparam int WIN_W   = $clog2(WINDOW + 1);
    localparam int WERR_W  = $clog2(ERR_LIMIT + 1);

    localparam logic [FILL_W-1:0]  FILL_LAST  = FILL_W'(NUM_BITS - 1);
    localparam logic [MATCH_W-1:0] MATCH_LAST = MATCH_W'(LOCK_CNT - 1);
    localparam logic [WIN_W-1:0]   WIN_LAST   = WIN_W'(WINDOW - 1);
    localparam logic [WERR_W-1:0]  WERR_LAST  = WERR_W'(ERR_LIMIT - 1);

    chk_state_t           state;
    logic [NUM_BITS-1:0]  lfsr;
    logic [FILL_W-1:0]    fill_cnt;
    logic [MATCH_W-1:0]   match_cnt;
    logic [WIN_W-1:0]     win_cnt;
    logic [WERR_W-1:0]    win_err;
    logic                 predicted;
    logic                 mismatch;
    logic                 lockup;

    lfsr_feedback #(
        .NUM_BITS (NUM_BITS)
    ) u_feedback (
        .lfsr_data (lfsr),
        .feedback  (predicted)
    );

    assign mismatch    = i_Bit ^ predicted;
    // All-ones is the XNOR lockup state: a stuck-high line would otherwise
    // predict itself perfectly and lock.
    assign lockup      = &lfsr;
    assign o_LFSR_Data = lfsr;

    always_ff @(posedge i_Clk) begin
        if (i_Rst) begin
            state       <= ST_FILL;
            lfsr        <= '0;
            fill_cnt    <= '0;
            match_cnt   <= '0;
            win_cnt     <= '0;
            win_err     <= '0;
            o_Locked    <= 1'b0;
            o_Bit_Err   <= 1'b0;
            o_Err_Count <= '0;
        end else begin
            o_Bit_Err <= 1'b0;
            if (i_Bit_DV) begin
                case (state)
                    ST_FILL: begin
                        lfsr <= {lfsr[NUM_BITS-2:0], i_Bit};
                        if (fill_cnt == FILL_LAST) begin
                            state     <= ST_CHECK;
                            fill_cnt  <= '0;
                            match_cnt <= '0;
                        end else begin
                            fill_cnt <= fill_cnt + FILL_W'(1);
                        end
                    end
                    ST_CHECK: begin
                        // Keep reloading from the line so a late slip re-aligns.
                        lfsr <= {lfsr[NUM_BITS-2:0], i_Bit};
                        if (lockup || mismatch) begin
                            match_cnt <= '0;
                        end else if (match_cnt == MATCH_LAST) begin
                            state     <= ST_LOCKED;
                            o_Locked  <= 1'b1;
                            match_cnt <= '0;
                            win_cnt   <= '0;
                            win_err   <= '0;
                        end else begin
                            match_cnt <= match_cnt + MATCH_W'(1);
                        end
                    end
                    ST_LOCKED: begin
                        // Flywheel: shift in our own prediction so a bad bit
                        // does not poison the following predictions.
                        lfsr      <= {lfsr[NUM_BITS-2:0], predicted};
                        o_Bit_Err <= mismatch;
                        if (mismatch && (o_Err_Count != {ERR_CNT_W{1'b1}})) begin
                            o_Err_Count <= o_Err_Count + ERR_CNT_W'(1);
                        end
                        // Error limit is tested before the window-close reset,
                        // so the closing bit's error still counts.
                        if (mismatch && (win_err == WERR_LAST)) begin
                            state    <= ST_FILL;
                            o_Locked <= 1'b0;
                            fill_cnt <= '0;
                            win_cnt  <= '0;
                            win_err  <= '0;
                        end else if (win_cnt == WIN_LAST) begin
                            win_cnt <= '0;
                            win_err <= '0;
                        end else begin
                            win_cnt <= win_cnt + WIN_W'(1);
                            win_err <= win_err + WERR_W'(mismatch);
                        end
                    end
                    default: begin
                        state    <= ST_FILL;
                        o_Locked <= 1'b0;
                        fill_cnt <= '0;
                    end
                endcase
            end
            if (i_Clr_Cnt) begin
                o_Err_Count <= '0;
            end
        end
    end

endmodule

// File: tb/tb_lfsr_checker.sv
// tb/tb_lfsr_checker.sv - self-checking bench for lfsr_checker
module tb_lfsr_checker;

    localparam int N       = 8;
    localparam int LCK     = 16;
    localparam int WIN     = 64;
    localparam int ELIM    = 4;
    localparam int CW      = 4;
    localparam int CNT_MAX = 15;

    logic          clk;
    logic          i_Rst;
    logic          i_Bit_DV;
    logic          i_Bit;
    logic          i_Clr_Cnt;
    logic          o_Locked;
    logic          o_Bit_Err;
    logic [CW-1:0] o_Err_Count;
    logic [N-1:0]  o_LFSR_Data;

    int n_cmp;
    int n_bad;

    lfsr_checker #(
        .NUM_BITS  (N),
        .LOCK_CNT  (LCK),
        .WINDOW    (WIN),
        .ERR_LIMIT (ELIM),
        .ERR_CNT_W (CW)
    ) dut (
        .i_Clk       (clk),
        .i_Rst       (i_Rst),
        .i_Bit_DV    (i_Bit_DV),
        .i_Bit       (i_Bit),
        .i_Clr_Cnt   (i_Clr_Cnt),
        .o_Locked    (o_Locked),
        .o_Bit_Err   (o_Bit_Err),
        .o_Err_Count (o_Err_Count),
        .o_LFSR_Data (o_LFSR_Data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: 8-bit polynomial taps 8,6,5,4 chained with XNOR.
    logic [N-1:0] g;
    string        m_state;
    logic [N-1:0] m_reg;
    int           m_fill, m_match, m_win, m_werr, m_cnt;
    logic         m_bit_err;

    function automatic logic ref_f(input logic [N-1:0] r);
        logic acc;
        acc = r[7];
        acc = ~(acc ^ r[5]);
        acc = ~(acc ^ r[4]);
        acc = ~(acc ^ r[3]);
        return acc;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_update(input logic dv, input logic b, input logic clr, input logic rst);
        logic p;
        logic m;
        m_bit_err = 1'b0;
        if (rst) begin
            m_state = "FILL";
            m_reg = '0;
            m_fill = 0; m_match = 0; m_win = 0; m_werr = 0; m_cnt = 0;
            return;
        end
        if (dv) begin
            p = ref_f(m_reg);
            m = (b != p);
            if (m_state == "FILL") begin
                m_reg = {m_reg[N-2:0], b};
                m_fill++;
                if (m_fill == N) begin
                    m_state = "CHECK";
                    m_match = 0;
                end
            end else if (m_state == "CHECK") begin
                if (m_reg == 8'hFF || m) m_match = 0;
                else m_match++;
                m_reg = {m_reg[N-2:0], b};
                if (m_match == LCK) begin
                    m_state = "LOCKED";
                    m_win = 0;
                    m_werr = 0;
                end
            end else begin
                m_reg = {m_reg[N-2:0], p};
                if (m) begin
                    m_bit_err = 1'b1;
                    if (m_cnt < CNT_MAX) m_cnt++;
                    m_werr++;
                end
                m_win++;
                if (m_werr == ELIM) begin
                    m_state = "FILL";
                    m_fill = 0;
                end else if (m_win == WIN) begin
                    m_win = 0;
                    m_werr = 0;
                end
            end
        end
        if (clr) m_cnt = 0;
    endtask

    task automatic step(input logic dv, input logic b, input logic clr, input logic rst);
        i_Bit_DV  = dv;
        i_Bit     = b;
        i_Clr_Cnt = clr;
        i_Rst     = rst;
        model_update(dv, b, clr, rst);
        @(posedge clk);
        #1;
        chk("locked",   {31'd0, o_Locked},   {31'd0, (m_state == "LOCKED")});
        chk("bit_err",  {31'd0, o_Bit_Err},  {31'd0, m_bit_err});
        chk("err_count", 32'(o_Err_Count),   32'(m_cnt));
        chk("lfsr_data", 32'(o_LFSR_Data),   32'(m_reg));
    endtask

    task automatic gen_next(output logic b);
        b = ref_f(g);
        g = {g[N-2:0], b};
    endtask

    task automatic send_gen(input logic inv, input logic clr);
        logic b;
        gen_next(b);
        step(1'b1, b ^ inv, clr, 1'b0);
    endtask

    initial begin
        int   lock_at;
        int   pulses;
        int   relock_n;
        int   drop_cycles;
        int   locked_cycles;
        int   valid_n;
        logic dv;

        n_cmp = 0;
        n_bad = 0;
        i_Rst = 1'b1; i_Bit_DV = 1'b0; i_Bit = 1'b0; i_Clr_Cnt = 1'b0;

        repeat (3) step(1'b0, 1'b0, 1'b0, 1'b1);
        chk("reset_locked", {31'd0, o_Locked}, 32'd0);
        chk("reset_count", 32'(o_Err_Count), 32'd0);

        // Clean stream from seed 0.
        g = '0;
        lock_at = -1;
        for (int i = 1; i <= 2000; i++) begin
            send_gen(1'b0, 1'b0);
            if (lock_at < 0 && o_Locked) lock_at = i;
        end
        chk("lock_latency", lock_at, 32'd24);
        chk("clean_count", 32'(o_Err_Count), 32'd0);

        // Single inverted bit after lock.
        step(1'b0, 1'b0, 1'b0, 1'b1);
        g = '0;
        pulses = 0;
        for (int i = 1; i <= 1000; i++) begin
            send_gen(i == 500, 1'b0);
            if (i == 500) chk("single_err_pulse", {31'd0, o_Bit_Err}, 32'd1);
            pulses += int'(o_Bit_Err);
        end
        chk("single_err_pulses", pulses, 32'd1);
        chk("single_err_count", 32'(o_Err_Count), 32'd1);
        chk("single_err_locked", {31'd0, o_Locked}, 32'd1);

        // Four errors in one window drop lock.
        for (int i = 1; i <= 7; i++) begin
            send_gen(i % 2 == 1, 1'b0);
            if (i == 5) chk("lock_held_3_errs", {31'd0, o_Locked}, 32'd1);
            if (i == 7) chk("lock_lost_4th_err", {31'd0, o_Locked}, 32'd0);
        end
        relock_n = 0;
        while (!o_Locked && relock_n < 200) begin
            send_gen(1'b0, 1'b0);
            relock_n++;
        end
        chk("relock_bits", relock_n, 32'd24);

        // Three errors per window hold lock; count saturates.
        drop_cycles = 0;
        for (int w = 0; w < 8; w++) begin
            for (int j = 0; j < WIN; j++) begin
                send_gen(j == 10 || j == 20 || j == 30, 1'b0);
                drop_cycles += int'(!o_Locked);
            end
        end
        chk("paced_errs_no_drop", drop_cycles, 32'd0);
        chk("count_saturated", 32'(o_Err_Count), 32'd15);

        // Clear coincident with an error.
        for (int j = 0; j < 25; j++) begin
            send_gen(j == 10 || j == 20, j == 10);
            if (j == 10) begin
                chk("clr_wins_count", 32'(o_Err_Count), 32'd0);
                chk("clr_err_pulse", {31'd0, o_Bit_Err}, 32'd1);
            end
        end
        chk("count_after_clr", 32'(o_Err_Count), 32'd1);

        // Reset while locked.
        step(1'b1, 1'b1, 1'b0, 1'b1);
        chk("rst_locked_drop", {31'd0, o_Locked}, 32'd0);
        chk("rst_count_zero", 32'(o_Err_Count), 32'd0);

        // Stuck-at-1, stuck-at-0, random data.
        locked_cycles = 0;
        for (int i = 0; i < 1000; i++) begin
            step(1'b1, 1'b1, 1'b0, 1'b0);
            locked_cycles += int'(o_Locked);
        end
        chk("stuck1_never_locks", locked_cycles, 32'd0);
        step(1'b0, 1'b0, 1'b0, 1'b1);
        locked_cycles = 0;
        for (int i = 0; i < 1000; i++) begin
            step(1'b1, 1'b0, 1'b0, 1'b0);
            locked_cycles += int'(o_Locked);
        end
        chk("stuck0_never_locks", locked_cycles, 32'd0);
        step(1'b0, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 1000; i++) begin
            step(1'b1, 1'($urandom_range(0, 1)), 1'b0, 1'b0);
        end

        // 30% valid duty on a clean stream.
        step(1'b0, 1'b0, 1'b0, 1'b1);
        g = '0;
        valid_n = 0;
        for (int c = 0; c < 3000 && !o_Locked; c++) begin
            dv = ($urandom_range(0, 99) < 30);
            if (dv) begin
                send_gen(1'b0, 1'b0);
                valid_n++;
            end else begin
                step(1'b0, 1'($urandom_range(0, 1)), 1'b0, 1'b0);
                chk("no_err_after_invalid", {31'd0, o_Bit_Err}, 32'd0);
            end
        end
        chk("dv_lock_valid_bits", valid_n, 32'd24);
        for (int c = 0; c < 500; c++) begin
            dv = ($urandom_range(0, 99) < 30);
            if (dv) send_gen(c == 100, 1'b0);
            else begin
                step(1'b0, 1'b0, 1'b0, 1'b0);
                chk("no_err_after_invalid", {31'd0, o_Bit_Err}, 32'd0);
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
